// File: rtl/universal_shift_reg.sv
// Universal WIDTH-bit register: hold, parallel load, shift/rotate either way,
// arithmetic shift right and synchronous clear, with asynchronous reset to RESET_VALUE.
module universal_shift_reg #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             C,
  input  logic             R,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIL,
  input  logic             SIR,
  output logic [WIDTH-1:0] Q,
  output logic             SOR,
  output logic             SOL,
  output logic             ZERO
);

  typedef enum logic [2:0] {
    ModeHold = 3'b000,
    ModeShr  = 3'b001,
    ModeShl  = 3'b010,
    ModeLoad = 3'b011,
    ModeRor  = 3'b100,
    ModeRol  = 3'b101,
    ModeAsr  = 3'b110,
    ModeClr  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (EN) begin
      case (mode_e'(MODE))
        ModeHold: q_d = q_q;
        ModeShr:  q_d = {SIR, q_q[WIDTH-1:1]};
        ModeShl:  q_d = {q_q[WIDTH-2:0], SIL};
        ModeLoad: q_d = D;
        ModeRor:  q_d = {q_q[0], q_q[WIDTH-1:1]};
        ModeRol:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        ModeAsr:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        // Clear goes to zero, deliberately not to RESET_VALUE.
        ModeClr:  q_d = '0;
        default:  q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q    = q_q;
  assign SOR  = q_q[0];
  assign SOL  = q_q[WIDTH-1];
  assign ZERO = (q_q == '0);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg: the driver queues hand-computed Q values,
// a monitor pops them at the falling clock edge (or on demand for async reset checks).
module tb_universal_shift_reg;

  localparam logic [2:0] HOLD = 3'b000;
  localparam logic [2:0] SHR  = 3'b001;
  localparam logic [2:0] SHL  = 3'b010;
  localparam logic [2:0] LOAD = 3'b011;
  localparam logic [2:0] ROR  = 3'b100;
  localparam logic [2:0] ROL  = 3'b101;
  localparam logic [2:0] ASR  = 3'b110;
  localparam logic [2:0] CLR  = 3'b111;

  logic       C = 1'b0;
  logic       R = 1'b0;
  logic       EN = 1'b0;
  logic [2:0] MODE = HOLD;
  logic [7:0] D = 8'h00;
  logic       SIL = 1'b0;
  logic       SIR = 1'b0;
  logic [7:0] Q;
  logic       SOR, SOL, ZERO;

  typedef struct {
    string      name;
    logic [7:0] q;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   checks = 0;
  int   failures = 0;

  universal_shift_reg #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5)
  ) dut (
    .C    (C),
    .R    (R),
    .EN   (EN),
    .MODE (MODE),
    .D    (D),
    .SIL  (SIL),
    .SIR  (SIR),
    .Q    (Q),
    .SOR  (SOR),
    .SOL  (SOL),
    .ZERO (ZERO)
  );

  always #5 C = ~C;

  task automatic check_bit(input string name, input string field, input logic got,
                           input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s.%s: got %b required %b", name, field, got, want);
    end
  endtask

  // Monitor: flags are derived from the expected Q, never from the DUT.
  initial begin
    exp_t e;
    forever begin
      @(negedge C or chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (Q !== e.q) begin
          failures++;
          $display("FAIL %s.Q: got %h required %h", e.name, Q, e.q);
        end
        check_bit(e.name, "SOR", SOR, e.q[0]);
        check_bit(e.name, "SOL", SOL, e.q[7]);
        check_bit(e.name, "ZERO", ZERO, e.q == 8'h00);
      end
    end
  end

  task automatic expect_q(input string name, input logic [7:0] q);
    exp_t e;
    e.name = name;
    e.q    = q;
    exp_q.push_back(e);
  endtask

  task automatic op(input string name, input logic en, input logic [2:0] mode,
                    input logic [7:0] d, input logic sil, input logic sir,
                    input logic [7:0] q);
    @(negedge C);
    EN   = en;
    MODE = mode;
    D    = d;
    SIL  = sil;
    SIR  = sir;
    @(posedge C);
    #1 expect_q(name, q);
  endtask

  initial begin
    logic [7:0] ror_seq [8];
    logic [7:0] asr_seq [8];
    int         wait_cycles;
    ror_seq = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};
    asr_seq = '{8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'hFF};

    // Async reset before any clock edge.
    #2 R = 1'b1;
    #1 expect_q("reset_async", 8'hA5);
    -> chk_ev;
    // Rising edge with R high and a LOAD pending has no effect.
    EN = 1'b1; MODE = LOAD; D = 8'h5A;
    @(posedge C);
    #1 expect_q("reset_edge_ignored", 8'hA5);
    @(negedge C);
    #2 R = 1'b0;

    op("load_3c", 1'b1, LOAD, 8'h3C, 1'b0, 1'b0, 8'h3C);
    for (int i = 0; i < 3; i++) op("hold", 1'b1, HOLD, 8'hFF, 1'b1, 1'b1, 8'h3C);
    op("en0_clr", 1'b0, CLR, 8'h00, 1'b0, 1'b0, 8'h3C);
    op("en0_load", 1'b0, LOAD, 8'hFF, 1'b0, 1'b0, 8'h3C);

    op("load_81", 1'b1, LOAD, 8'h81, 1'b0, 1'b0, 8'h81);
    op("shr_sir0", 1'b1, SHR, 8'h00, 1'b1, 1'b0, 8'h40);
    op("load_81", 1'b1, LOAD, 8'h81, 1'b0, 1'b0, 8'h81);
    op("shl_sil1", 1'b1, SHL, 8'h00, 1'b1, 1'b0, 8'h03);
    op("load_81", 1'b1, LOAD, 8'h81, 1'b0, 1'b0, 8'h81);
    op("asr_81", 1'b1, ASR, 8'h00, 1'b0, 1'b0, 8'hC0);
    op("asr_c0", 1'b1, ASR, 8'h00, 1'b0, 1'b0, 8'hE0);

    op("load_81", 1'b1, LOAD, 8'h81, 1'b0, 1'b0, 8'h81);
    for (int i = 0; i < 8; i++) op("ror_wrap", 1'b1, ROR, 8'h00, 1'b0, 1'b0, ror_seq[i]);
    op("rol_81", 1'b1, ROL, 8'h00, 1'b0, 1'b0, 8'h03);
    op("rol_03", 1'b1, ROL, 8'h00, 1'b1, 1'b0, 8'h06);

    op("load_ff", 1'b1, LOAD, 8'hFF, 1'b0, 1'b0, 8'hFF);
    op("clr_ff", 1'b1, CLR, 8'hFF, 1'b0, 1'b0, 8'h00);
    op("load_01", 1'b1, LOAD, 8'h01, 1'b0, 1'b0, 8'h01);
    op("shr_sir1", 1'b1, SHR, 8'h00, 1'b0, 1'b1, 8'h80);
    for (int i = 0; i < 8; i++) op("asr_sat", 1'b1, ASR, 8'h00, 1'b0, 1'b1, asr_seq[i]);
    op("load_7f", 1'b1, LOAD, 8'h7F, 1'b0, 1'b0, 8'h7F);
    for (int i = 0; i < 8; i++) op("shr_drain", 1'b1, SHR, 8'h00, 1'b1, 1'b0, 8'h7F >> (i + 1));

    // Reset pulse in the middle of a continuous shift-left.
    op("load_00", 1'b1, LOAD, 8'h00, 1'b0, 1'b0, 8'h00);
    op("shl_run", 1'b1, SHL, 8'h00, 1'b1, 1'b0, 8'h01);
    op("shl_run", 1'b1, SHL, 8'h00, 1'b1, 1'b0, 8'h03);
    @(negedge C);
    #1 R = 1'b1;
    #1 expect_q("reset_pulse", 8'hA5);
    -> chk_ev;
    #2 R = 1'b0;
    @(posedge C);
    #1 expect_q("shl_after_reset", 8'h4B);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge C);
      wait_cycles++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish required finish by 20000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised universal register: a WIDTH-bit bank of flip-flops with an asynchronous reset to a configurable value. On each rising clock edge it can hold, load in parallel, shift or rotate in either direction, arithmetic-shift right, or clear synchronously. It replaces hand-chained single-bit DFF instances wherever the datapath needs a shift register, accumulator shadow or serial/parallel converter.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VALUE, {WIDTH{1'b0}}, value forced onto Q while R is high. Any WIDTH-bit constant is legal.
- C  input  1  clock; all state changes on its rising edge.
- R  input  1  reset, asynchronous, active-high. While high, Q = RESET_VALUE regardless of C.
- EN  input  1  clock enable. When 0, state holds for every MODE.
- MODE  input  3  operation select, sampled at the rising edge of C.
- D  input  WIDTH  parallel load data.
- SIL  input  1  serial input for shift-left; enters at bit 0.
- SIR  input  1  serial input for shift-right; enters at bit WIDTH-1.
- Q  output  WIDTH  register contents.
- SOR  output  1  Q[0], the bit lost on the next right shift (combinational from Q).
- SOL  output  1  Q[WIDTH-1], the bit lost on the next left shift (combinational from Q).
- ZERO  output  1  1 when Q == 0 (combinational from Q).

## Operation
- Reset: R high sets Q = RESET_VALUE immediately, without waiting for C.
  - Reset-derived outputs: SOR = RESET_VALUE[0], SOL = RESET_VALUE[WIDTH-1], ZERO = (RESET_VALUE == 0).
- At the rising edge of C, with R low and EN = 1, MODE selects the next Q:
  - 000 HOLD: Q unchanged.
  - 001 SHR: Q = {SIR, Q[WIDTH-1:1]}.
  - 010 SHL: Q = {Q[WIDTH-2:0], SIL}.
  - 011 LOAD: Q = D.
  - 100 ROR: Q = {Q[0], Q[WIDTH-1:1]}. SIR is ignored.
  - 101 ROL: Q = {Q[WIDTH-2:0], Q[WIDTH-1]}. SIL is ignored.
  - 110 ASR: Q = {Q[WIDTH-1], Q[WIDTH-1:1]}. The sign bit is replicated and SIR is ignored.
  - 111 CLR: Q = 0. This is a synchronous clear to zero, not to RESET_VALUE.
- EN = 0: Q holds for every MODE, including CLR and LOAD.
- No internal state exists beyond Q. There is no FSM; each edge is independent.
- Serial chaining: SOR of stage n drives SIR of stage n+1 to form wider right-shift chains. SOL chains the same way for left shifts.

## Timing
- Latency: one cycle. Q reflects the operation at the rising edge of C where MODE, EN, D, SIL and SIR were sampled.
- SOR, SOL and ZERO are combinational from Q and follow Q within the same cycle.
- R has priority over C. Behaviour at the boundaries is:
  - Rising edge of C while R is high: no effect.
  - R asserted mid-cycle: Q goes to RESET_VALUE at once.
  - R released: the first operation takes effect at the first rising edge of C with R low. R and C must not fall and rise at the same instant; the bench keeps at least 1 ns of separation.
- Wrap-around: after WIDTH consecutive ROR or ROL operations, Q equals its original value. After WIDTH SHR operations with SIR = 0, Q = 0.
- ASR saturation: repeated ASR converges to all-ones if Q[WIDTH-1] = 1, and to 0 otherwise. It never changes after convergence.
- X on MODE with EN = 1: Q may become X. The bench never drives this.

## Test plan
- Reset: WIDTH = 8, RESET_VALUE = 8'hA5. Assert R between clock edges.
  - Required: Q = 8'hA5, SOR = 1, SOL = 1, ZERO = 0, before any edge of C.
- Load and hold: LOAD D = 8'h3C, then HOLD ×3, then EN = 0 with MODE = CLR.
  - Required: Q = 8'h3C throughout.
- Shifts from Q = 8'h81:
  - SHR with SIR = 0 gives Q = 8'h40.
  - SHL with SIL = 1 from 8'h81 gives Q = 8'h03.
  - ASR from 8'h81 gives Q = 8'hC0.
- Rotate: from 8'h81, ROR gives 8'hC0; 8 consecutive RORs give 8'h81; ROL from 8'h81 gives 8'h03.
- Clear and flags: CLR from 8'hFF gives Q = 0 and ZERO = 1. A following LOAD 8'h01 gives ZERO = 0 and SOR = 1.
- Reset mid-operation: continuous SHL with SIL = 1, then pulse R for 3 ns between edges.
  - Required: Q = 8'hA5 during the pulse.
  - The first edge after release gives 8'h4B.
